reorder_buffer: RTL

Circular in-order reorder buffer between the Dispatcher, the execution units (ALU, LSB) and the register file. It allocates one entry per dispatched instruction and captures results from the ALU and LSB write-back buses. It retires at most one instruction per cycle in program order, drives the register-file commit port, releases stores to the LSB and redirects fetch on a branch mispredict.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer_if.sv | 58 +++++
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared widths and entry encodings for reorder_buffer
package reorder_buffer_pkg;
   localparam int RoB_WIDTH    = 8;
   localparam int RoB_SIZE     = 1 << RoB_WIDTH;
   localparam int EX_REG_WIDTH = 6;
   localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;
   localparam logic [RoB_WIDTH:0] RoB_FULL_COUNT = (RoB_WIDTH+1)'(RoB_SIZE);

   typedef enum logic [1:0] {
      TYPE_REG    = 2'd0,
      TYPE_BRANCH = 2'd1,
      TYPE_STORE  = 2'd2
   } rob_type_e;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FLUSH  = 1'b1
   } rob_state_e;
endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, write-back and commit buses of reorder_buffer (ROB_PRED_UPDATE_EN adds predictor update)
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic                      DPRoB_en;
   logic [1:0]                DPRoB_type;
   logic [EX_REG_WIDTH-1:0]   DPRoB_rd;
   logic                      DPRoB_pred_jump;
   logic [31:0]               DPRoB_pc;
   logic [31:0]               DPRoB_alt_pc;
   logic                      RoBDP_full;
   logic [RoB_WIDTH-1:0]      RoBDP_RoB_index;
   logic                      ALURoB_en;
   logic [RoB_WIDTH-1:0]      ALURoB_RoB_index;
   logic [31:0]               ALURoB_value;
   logic                      ALURoB_jump;
   logic                      LSBRoB_en;
   logic [RoB_WIDTH-1:0]      LSBRoB_RoB_index;
   logic [31:0]               LSBRoB_value;
   logic                      RoBRF_en;
   logic [RoB_WIDTH-1:0]      RoBRF_RoB_index;
   logic [4:0]                RoBRF_rd;
   logic [31:0]               RoBRF_value;
   logic                      RoBRF_pre_judge;
   logic                      RoBLSB_commit_en;
   logic [RoB_WIDTH-1:0]      RoBLSB_RoB_index;
   logic                      RoBIF_jump_en;
   logic [31:0]               RoBIF_next_pc;
`ifdef ROB_PRED_UPDATE_EN
   logic                      RoBPred_en;
   logic [31:0]               RoBPred_pc;
   logic                      RoBPred_taken;
`endif

   modport master (
      output DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_jump, DPRoB_pc, DPRoB_alt_pc,
      output ALURoB_en, ALURoB_RoB_index, ALURoB_value, ALURoB_jump,
      output LSBRoB_en, LSBRoB_RoB_index, LSBRoB_value,
      input  RoBDP_full, RoBDP_RoB_index,
      input  RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
      input  RoBLSB_commit_en, RoBLSB_RoB_index, RoBIF_jump_en, RoBIF_next_pc
`ifdef ROB_PRED_UPDATE_EN
      , input RoBPred_en, RoBPred_pc, RoBPred_taken
`endif
   );

   modport slave (
      input  DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_jump, DPRoB_pc, DPRoB_alt_pc,
      input  ALURoB_en, ALURoB_RoB_index, ALURoB_value, ALURoB_jump,
      input  LSBRoB_en, LSBRoB_RoB_index, LSBRoB_value,
      output RoBDP_full, RoBDP_RoB_index,
      output RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
      output RoBLSB_commit_en, RoBLSB_RoB_index, RoBIF_jump_en, RoBIF_next_pc
`ifdef ROB_PRED_UPDATE_EN
      , output RoBPred_en, RoBPred_pc, RoBPred_taken
`endif
   );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer; ROB_PRED_UPDATE_EN enables branch-outcome updates to the predictor
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic             Sys_clk,
   input  logic             Sys_rst,
   input  logic             Sys_rdy,
   reorder_buffer_if.slave  rob
);
   rob_state_e                state;
   logic [RoB_WIDTH-1:0]      head, tail;
   logic [RoB_WIDTH:0]        count, count_next;
   logic [RoB_SIZE-1:0]       busy, ready;
   rob_type_e                 e_type    [RoB_SIZE];
   logic [4:0]                e_rd      [RoB_SIZE];
   logic [31:0]               e_value   [RoB_SIZE];
   logic [31:0]               e_alt_pc  [RoB_SIZE];
   logic [RoB_SIZE-1:0]       e_pred_jump, e_real_jump;
`ifdef ROB_PRED_UPDATE_EN
   logic [31:0]               e_pc      [RoB_SIZE];
   logic                      unused_bits;
   assign unused_bits = rob.DPRoB_rd[EX_REG_WIDTH-1];
`else
   logic                      unused_bits;
   assign unused_bits = ^{rob.DPRoB_rd[EX_REG_WIDTH-1], rob.DPRoB_pc};
`endif
   logic alloc, alu_wb, lsb_wb, commit, mispredict;

   assign rob.RoBDP_full      = (count == RoB_FULL_COUNT) || (state == ST_FLUSH);
   assign rob.RoBDP_RoB_index = tail;

   // A mispredict squashes everything presented in the same cycle.
   always_comb begin
      commit     = Sys_rdy && (state == ST_NORMAL) && busy[head] && ready[head];
      mispredict = commit && (e_type[head] == TYPE_BRANCH) && (e_pred_jump[head] != e_real_jump[head]);
      alloc      = Sys_rdy && rob.DPRoB_en && !rob.RoBDP_full && !mispredict;
      alu_wb     = Sys_rdy && (state == ST_NORMAL) && !mispredict && rob.ALURoB_en && busy[rob.ALURoB_RoB_index];
      lsb_wb     = Sys_rdy && (state == ST_NORMAL) && !mispredict && rob.LSBRoB_en && busy[rob.LSBRoB_RoB_index];
      count_next = count;
      if (alloc && !commit)
         count_next = count + (RoB_WIDTH+1)'(1);
      else if (commit && !alloc)
         count_next = count - (RoB_WIDTH+1)'(1);
   end

   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         state                <= ST_NORMAL;
         head                 <= '0;
         tail                 <= '0;
         count                <= '0;
         busy                 <= '0;
         ready                <= '0;
         rob.RoBRF_en         <= 1'b0;
         rob.RoBRF_RoB_index  <= '0;
         rob.RoBRF_rd         <= '0;
         rob.RoBRF_value      <= '0;
         rob.RoBRF_pre_judge  <= 1'b1;
         rob.RoBLSB_commit_en <= 1'b0;
         rob.RoBLSB_RoB_index <= '0;
         rob.RoBIF_jump_en    <= 1'b0;
         rob.RoBIF_next_pc    <= '0;
`ifdef ROB_PRED_UPDATE_EN
         rob.RoBPred_en       <= 1'b0;
         rob.RoBPred_pc       <= '0;
         rob.RoBPred_taken    <= 1'b0;
`endif
      end else if (Sys_rdy) begin
         rob.RoBRF_en         <= 1'b0;
         rob.RoBRF_pre_judge  <= 1'b1;
         rob.RoBLSB_commit_en <= 1'b0;
         rob.RoBIF_jump_en    <= 1'b0;
`ifdef ROB_PRED_UPDATE_EN
         rob.RoBPred_en       <= 1'b0;
         if (commit && (e_type[head] == TYPE_BRANCH)) begin
            rob.RoBPred_en    <= 1'b1;
            rob.RoBPred_pc    <= e_pc[head];
            rob.RoBPred_taken <= e_real_jump[head];
         end
`endif
         if (state == ST_FLUSH) begin
            state <= ST_NORMAL;
         end else if (mispredict) begin
            state                <= ST_FLUSH;
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            busy                 <= '0;
            rob.RoBRF_pre_judge  <= 1'b0;
            rob.RoBIF_jump_en    <= 1'b1;
            rob.RoBIF_next_pc    <= e_alt_pc[head];
         end else begin
            if (alloc) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               tail        <= tail + RoB_WIDTH'(1);
            end
            if (alu_wb)
               ready[rob.ALURoB_RoB_index] <= 1'b1;
            if (lsb_wb)
               ready[rob.LSBRoB_RoB_index] <= 1'b1;
            if (commit) begin
               busy[head] <= 1'b0;
               head       <= head + RoB_WIDTH'(1);
               case (e_type[head])
                  TYPE_REG: begin
                     rob.RoBRF_en        <= 1'b1;
                     rob.RoBRF_RoB_index <= head;
                     rob.RoBRF_rd        <= e_rd[head];
                     rob.RoBRF_value     <= e_value[head];
                  end
                  TYPE_STORE: begin
                     rob.RoBLSB_commit_en <= 1'b1;
                     rob.RoBLSB_RoB_index <= head;
                  end
                  default: ;
               endcase
            end
            count <= count_next;
         end
      end else begin
         rob.RoBRF_en         <= 1'b0;
         rob.RoBRF_pre_judge  <= 1'b1;
         rob.RoBLSB_commit_en <= 1'b0;
         rob.RoBIF_jump_en    <= 1'b0;
`ifdef ROB_PRED_UPDATE_EN
         rob.RoBPred_en       <= 1'b0;
`endif
      end
   end

   // Payload storage needs no reset: busy/ready gate every use of it.
   always_ff @(posedge Sys_clk) begin
      if (alloc) begin
         e_type[tail]      <= rob_type_e'(rob.DPRoB_type);
         e_rd[tail]        <= rob.DPRoB_rd[4:0];
         e_pred_jump[tail] <= rob.DPRoB_pred_jump;
         e_alt_pc[tail]    <= rob.DPRoB_alt_pc;
`ifdef ROB_PRED_UPDATE_EN
         e_pc[tail]        <= rob.DPRoB_pc;
`endif
      end
      if (alu_wb) begin
         e_value[rob.ALURoB_RoB_index]     <= rob.ALURoB_value;
         e_real_jump[rob.ALURoB_RoB_index] <= rob.ALURoB_jump;
      end
      if (lsb_wb)
         e_value[rob.LSBRoB_RoB_index] <= rob.LSBRoB_value;
   end
endmodule
